// File: rtl/display_write_scheduler.sv
// Two-source display write scheduler: round-robin arbiter into a small FIFO
// that issues at most one display write per cycle, with a stall after a display clear.
module display_write_scheduler #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] CLEAR_ADDR = 32'h1800,
    parameter int          CLEAR_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_req,
    input  logic [31:0]                cpu_addr,
    input  logic [31:0]                cpu_data,
    output logic                       cpu_ready,
    input  logic                       aux_req,
    input  logic [31:0]                aux_addr,
    input  logic [31:0]                aux_data,
    output logic                       aux_ready,
    output logic                       disp_en,
    output logic [31:0]                disp_addr,
    output logic [31:0]                disp_value,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy,
    output logic                       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(CLEAR_HOLD + 2);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [0:0]    state;
    logic [HW-1:0] hold_cnt;
    logic          last_grant_aux;

    logic          full;
    logic          push;
    logic          pop;
    logic [63:0]   push_word;
    logic [63:0]   head;
    logic          head_is_clear;

    // Handshake: a transfer happens on a rising edge where req && ready; ready is
    // combinational, never raised for an idle source, and never for both at once.
    always_comb begin
        full      = (count == CW'(DEPTH));
        cpu_ready = ~full & cpu_req & (~aux_req | last_grant_aux);
        aux_ready = ~full & aux_req & (~cpu_req | ~last_grant_aux);
        push      = cpu_ready | aux_ready;
        push_word = cpu_ready ? {cpu_addr, cpu_data} : {aux_addr, aux_data};
        head      = mem[rd_ptr];
        head_is_clear = (head[63:32] == CLEAR_ADDR);
        pop       = (state == ST_RUN) && (count != '0);
    end

    // Storage needs no reset: occupancy is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            state          <= ST_RUN;
            hold_cnt       <= '0;
            last_grant_aux <= 1'b1;
            disp_en        <= 1'b0;
            disp_addr      <= '0;
            disp_value     <= '0;
        end else begin
            if (push) begin
                wr_ptr         <= wr_ptr + AW'(1);
                last_grant_aux <= aux_ready;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                disp_addr  <= head[63:32];
                disp_value <= head[31:0];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            disp_en <= pop;

            case (state)
                ST_RUN: begin
                    if (pop && head_is_clear && (CLEAR_HOLD > 0)) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HW'(CLEAR_HOLD);
                    end
                end
                default: begin
                    // Leaving on the count of 1 puts the next strobe CLEAR_HOLD+1 cycles after the clear.
                    if (hold_cnt == HW'(1)) begin
                        state    <= ST_RUN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        fifo_count = count;
        busy       = (count != '0) | (state == ST_HOLD) | disp_en;
        dbg_state  = state[0];
    end

endmodule

// File: tb/tb_display_write_scheduler.sv
// Directed bench for display_write_scheduler: accepted writes feed an expected
// queue that every display strobe is checked against.
module tb_display_write_scheduler;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] CLEAR_ADDR = 32'h1800;
    localparam int          CLEAR_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic        aux_req;
    logic [31:0] aux_addr;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        disp_en;
    logic [31:0] disp_addr;
    logic [31:0] disp_value;
    logic [$clog2(DEPTH):0] fifo_count;
    logic        busy;
    logic        dbg_state;

    logic [63:0] exp_q[$];
    int          strobe_cyc[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          cyc       = 0;
    logic        model_last_aux;
    logic        cpu_xfer;
    logic        aux_xfer;
    int          cpu_n;
    int          aux_n;
    int          stall_n;

    always #5 clk = ~clk;

    display_write_scheduler #(
        .DEPTH(DEPTH), .CLEAR_ADDR(CLEAR_ADDR), .CLEAR_HOLD(CLEAR_HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_data(aux_data), .aux_ready(aux_ready),
        .disp_en(disp_en), .disp_addr(disp_addr), .disp_value(disp_value),
        .fifo_count(fifo_count), .busy(busy), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: record accepted writes, cross the edge, then check any strobe.
    task automatic step();
        logic [63:0] got;
        #2;
        cpu_xfer = cpu_req && cpu_ready;
        aux_xfer = aux_req && aux_ready;
        chk("ready_without_req", 64'({cpu_ready & ~cpu_req, aux_ready & ~aux_req}), 64'(0));
        if (cpu_req && aux_req)
            chk("tie_grant", 64'({cpu_ready, aux_ready}), model_last_aux ? 64'(2'b10) : 64'(2'b01));
        if (cpu_xfer) begin
            exp_q.push_back({cpu_addr, cpu_data});
            model_last_aux = 1'b0;
        end
        if (aux_xfer) begin
            exp_q.push_back({aux_addr, aux_data});
            model_last_aux = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (disp_en) begin
            strobe_cyc.push_back(cyc);
            chk("strobe_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                got = {disp_addr, disp_value};
                chk("disp_order", got, exp_q.pop_front());
            end
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_disp_en"}, 64'(disp_en), 64'(0));
        chk({tag, "_disp_addr"}, 64'(disp_addr), 64'(0));
        chk({tag, "_disp_value"}, 64'(disp_value), 64'(0));
        chk({tag, "_fifo_count"}, 64'(fifo_count), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_state_run"}, 64'(dbg_state), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
        aux_req = 1'b0; aux_addr = '0; aux_data = '0;
        model_last_aux = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        // Single CPU write: strobe only in the cycle after the pop edge.
        cpu_req = 1'b1; cpu_addr = 32'h24; cpu_data = 32'hAB;
        step();
        cpu_req = 1'b0;
        chk("t2_no_strobe_at_accept", 64'(disp_en), 64'(0));
        chk("t2_count_one", 64'(fifo_count), 64'(1));
        step();
        chk("t2_strobe", 64'(disp_en), 64'(1));
        step();
        chk("t2_strobe_single", 64'(disp_en), 64'(0));
        chk("t2_addr_held", 64'(disp_addr), 64'(32'h24));

        // Asynchronous reset with an entry queued and stale display registers.
        cpu_req = 1'b1; cpu_addr = 32'h50; cpu_data = 32'h55;
        step();
        cpu_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        model_last_aux = 1'b1;
        #1;
        rst = 1'b0;

        // Both sources held: CPU wins first tie, then strict alternation.
        cpu_n = 0; aux_n = 0;
        cpu_req = 1'b1; cpu_addr = 32'h100; cpu_data = 32'hC000;
        aux_req = 1'b1; aux_addr = 32'h200; aux_data = 32'hA000;
        #2;
        chk("t3_first_tie_cpu", 64'({cpu_ready, aux_ready}), 64'(2'b10));
        for (int i = 0; i < 40 && (cpu_n < 6 || aux_n < 6); i++) begin
            step();
            if (cpu_xfer) begin
                cpu_n++;
                cpu_addr = 32'h100 + 32'(4 * cpu_n); cpu_data = 32'hC000 + 32'(cpu_n);
                if (cpu_n == 6) cpu_req = 1'b0;
            end
            if (aux_xfer) begin
                aux_n++;
                aux_addr = 32'h200 + 32'(4 * aux_n); aux_data = 32'hA000 + 32'(aux_n);
                if (aux_n == 6) aux_req = 1'b0;
            end
        end
        chk("t3_cpu_writes", 64'(cpu_n), 64'(6));
        chk("t3_aux_writes", 64'(aux_n), 64'(6));
        drain(20);

        // Clear at head stalls the display while the aux source fills the FIFO.
        cpu_req = 1'b1; cpu_addr = CLEAR_ADDR; cpu_data = 32'hC1;
        step();
        cpu_req = 1'b0;
        aux_n = 0;
        aux_req = 1'b1; aux_addr = 32'h300; aux_data = 32'hB000;
        for (int i = 0; i < 12 && aux_n < 4; i++) begin
            step();
            if (aux_xfer) begin
                aux_n++;
                aux_addr = 32'h300 + 32'(4 * aux_n); aux_data = 32'hB000 + 32'(aux_n);
            end
        end
        chk("t4_full_count", 64'(fifo_count), 64'(DEPTH));
        chk("t4_full_not_ready", 64'(aux_ready), 64'(0));
        chk("t4_busy_hold", 64'(busy), 64'(1));
        stall_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (aux_ready) break;
            step();
            stall_n++;
        end
        // Full after the 4th push, first pop lands CLEAR_HOLD+1 edges after the clear pop.
        chk("t4_stall_cycles", 64'(stall_n), 64'(CLEAR_HOLD - 2));
        chk("t4_ready_back", 64'(aux_ready), 64'(1));
        chk("t4_ready_after_pop", 64'(disp_en), 64'(1));
        chk("t4_count_after_pop", 64'(fifo_count), 64'(DEPTH - 1));
        aux_req = 1'b0;
        drain(20);

        // Clear spacing: CLEAR_HOLD idle cycles, then back-to-back strobes.
        strobe_cyc.delete();
        cpu_req = 1'b1; cpu_addr = CLEAR_ADDR; cpu_data = 32'h0;
        step();
        cpu_addr = 32'h10; cpu_data = 32'h1010;
        step();
        cpu_addr = 32'h14; cpu_data = 32'h1414;
        step();
        cpu_req = 1'b0;
        drain(30);
        chk("t5_strobes", 64'(strobe_cyc.size()), 64'(3));
        if (strobe_cyc.size() == 3) begin
            chk("t5_clear_gap", 64'(strobe_cyc[1] - strobe_cyc[0]), 64'(CLEAR_HOLD + 1));
            chk("t5_back_to_back", 64'(strobe_cyc[2] - strobe_cyc[1]), 64'(1));
        end

        // Reset during HOLD with three queued entries discards them all.
        cpu_req = 1'b1; cpu_addr = CLEAR_ADDR; cpu_data = 32'h6;
        step();
        for (int k = 0; k < 3; k++) begin
            cpu_addr = 32'h30 + 32'(4 * k); cpu_data = 32'h3000 + 32'(k);
            step();
        end
        cpu_req = 1'b0;
        step();
        step();
        chk("t6_queued", 64'(fifo_count), 64'(3));
        chk("t6_in_hold", 64'(dbg_state), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        exp_q.delete();
        model_last_aux = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t6_quiet", 64'(disp_en), 64'(0));
        end
        cpu_req = 1'b1; cpu_addr = 32'h40; cpu_data = 32'h4040;
        step();
        cpu_req = 1'b0;
        drain(10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
